// File: rtl/score_bcd_pkg.sv
// Shared constants for the binary-to-BCD score converter: operand/digit
// widths, saturation limit, counter width and FSM state encodings.
package score_bcd_pkg;
    localparam int BIN_W  = 27;
    localparam int DIGITS = 8;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(BIN_W);

    localparam logic [BIN_W-1:0] MAX_VAL = 27'd99_999_999;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any digit of 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_add3 (
    input  logic [3:0] nib,
    output logic [3:0] fixed
);
    assign fixed = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

// File: rtl/score_bcd.sv
// Iterative binary-to-BCD converter, one operand bit per clock; done pulses BIN_W+1
// clocks after the accepting start edge, start ignored while busy, result held between runs.
module score_bcd
    import score_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd,
    output logic             ovf
);
    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [BIN_W-1:0] opr;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_fix;
    logic             ovf_pend;

    for (genvar g = 0; g < DIGITS; g++) begin : g_fix
        bcd_add3 u_add3 (
            .nib   (acc[4*g +: 4]),
            .fixed (acc_fix[4*g +: 4])
        );
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state    <= S_IDLE;
            count    <= '0;
            opr      <= '0;
            acc      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Out-of-range scores saturate so the display shows all nines.
                        if (bin > MAX_VAL) begin
                            opr      <= MAX_VAL;
                            ovf_pend <= 1'b1;
                        end else begin
                            opr      <= bin;
                            ovf_pend <= 1'b0;
                        end
                        acc   <= '0;
                        count <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc   <= {acc_fix[BCD_W-2:0], opr[BIN_W-1]};
                    opr   <= {opr[BIN_W-2:0], 1'b0};
                    count <= count + 1'b1;
                    if (count == CNT_W'(BIN_W - 1)) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd   <= acc;
                    ovf   <= ovf_pend;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
